// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants for the nibble-serial adder
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - 4-bit ripple-carry adder built from full-adder cells
module ripple_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder that reuses one 4-bit adder, one nibble per cycle
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic [1:0]       state;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] sum_shift;
  logic             last;

  ripple_carry_adder u_rca (
    .A    (a_sh[NIBBLE_W-1:0]),
    .B    (b_sh[NIBBLE_W-1:0]),
    .Cin  (carry),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  // Result fills from the top so after NIBBLES shifts the first nibble sits at bit 0.
  if (WIDTH == NIBBLE_W) begin : g_one_nibble
    assign sum_shift = nib_sum;
  end else begin : g_multi_nibble
    assign sum_shift = {nib_sum, sum_r[WIDTH-1:NIBBLE_W]};
  end

  assign last      = (cnt == CW'(NIBBLES - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Sum       = sum_r;
  assign Cout      = cout_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          sum_r <= sum_shift;
          carry <= nib_cout;
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cout_r <= nib_cout;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, cout;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .Cout(cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .Cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .Sum(sum4), .Cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and return the number of edges until out_valid (bounded).
  task automatic start_and_wait(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                                output int edges);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
      edges++;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic [15:0] es, input logic ec);
    int n;
    out_ready = 1'b1;
    start_and_wait(ta, tb_, tc, n);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    tick();
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    do_op("msb_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // Backpressure: result must hold and new operands must be refused.
    out_ready = 1'b0;
    start_and_wait(16'h00F0, 16'h0F10, 1'b0, n);
    chk("bp_latency", n, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'h1111 * (i + 1); b = 16'h2222; cin = 1'b1;
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h1000);
      chk("bp_cout", cout, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_no_accept", in_ready, 1);

    // Reset two ADD edges into an operation.
    a = 16'h7777; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ready", in_ready, 1);
    tick();
    chk("midrst_hold_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_result", out_valid, 0);
    end
    do_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);

    // Single-nibble instance: result after one edge.
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    chk("w4_busy", in_ready4, 0);
    tick();
    chk("w4_valid", out_valid4, 1);
    chk("w4_sum", sum4, 4'h0);
    chk("w4_cout", cout4, 1);
    tick();
    chk("w4_valid_drop", out_valid4, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
